// File: rtl/load_store_unit.sv
// Load/store access controller between the core and a word-wide, async-read data memory.
// Handles sub-word extraction/extension on loads and read-modify-write merging on sub-word stores.
module load_store_unit #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [2:0]            ReqFunct3,
  input  logic [31:0]           ReqAddr,
  input  logic [31:0]           ReqWData,
  output logic                  RespValid,
  output logic [31:0]           RespRData,
  output logic                  RespErr,
  output logic [ADDR_WIDTH-1:0] DMemAddr,
  output logic                  DMemWrite,
  output logic [31:0]           DMemWData,
  input  logic [31:0]           DMemRData
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t                state_q, state_d;
  logic                  write_q;
  logic                  err_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           buf_q;

  logic                  accept;
  logic                  req_err;
  logic                  illegal;
  logic                  misaligned;
  logic [31:0]           merged;
  logic [31:0]           lane_word;
  logic [31:0]           half_word;
  logic                  unused_addr;

  assign unused_addr = ^ReqAddr[31:ADDR_WIDTH+2];
  assign accept      = ReqValid && ReqReady;

  always_comb begin
    illegal    = 1'b1;
    misaligned = 1'b0;
    if (ReqWrite) begin
      illegal = !(ReqFunct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      illegal = !(ReqFunct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
    if (ReqFunct3[1:0] == 2'b01) misaligned = ReqAddr[0];
    if (ReqFunct3[1:0] == 2'b10) misaligned = (ReqAddr[1:0] != 2'b00);
  end

  assign req_err = illegal || misaligned;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= ReqWrite;
        err_q    <= req_err;
        funct3_q <= ReqFunct3;
        addr_q   <= ReqAddr[ADDR_WIDTH+1:0];
        wdata_q  <= ReqWData;
      end
      if (state_q == RD) buf_q <= DMemRData;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                            state_d = RESP;
          else if (ReqWrite && ReqFunct3 == 3'b010) state_d = WR;
          else                                    state_d = RD;
        end
      end
      RD:      state_d = write_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    merged = buf_q;
    unique case (funct3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign lane_word = buf_q >> {addr_q[1:0], 3'b000};
  assign half_word = buf_q >> {addr_q[1], 4'b0000};

  always_comb begin
    RespRData = 32'h0;
    if (state_q == RESP && !err_q && !write_q) begin
      unique case (funct3_q)
        3'b000:  RespRData = {{24{lane_word[7]}}, lane_word[7:0]};
        3'b001:  RespRData = {{16{half_word[15]}}, half_word[15:0]};
        3'b010:  RespRData = buf_q;
        3'b100:  RespRData = {24'h0, lane_word[7:0]};
        3'b101:  RespRData = {16'h0, half_word[15:0]};
        default: RespRData = 32'h0;
      endcase
    end
  end

  // Outputs decode the asynchronously reset state, so DMemWrite drops the moment rst_n falls.
  assign ReqReady  = (state_q == IDLE);
  assign RespValid = (state_q == RESP);
  assign RespErr   = (state_q == RESP) && err_q;
  assign DMemWrite = (state_q == WR);
  assign DMemWData = (state_q == WR) ? merged : 32'h0;
  assign DMemAddr  = addr_q[ADDR_WIDTH+1:2];

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed test-plan steps plus randomized traffic
// compared against a byte-array reference memory.
module tb_load_store_unit;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ReqValid;
  logic          ReqReady;
  logic          ReqWrite;
  logic [2:0]    ReqFunct3;
  logic [31:0]   ReqAddr;
  logic [31:0]   ReqWData;
  logic          RespValid;
  logic [31:0]   RespRData;
  logic          RespErr;
  logic [AW-1:0] DMemAddr;
  logic          DMemWrite;
  logic [31:0]   DMemWData;
  logic [31:0]   DMemRData;

  logic [31:0]   mem [64];
  logic [7:0]    ref_b [256];

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqFunct3(ReqFunct3), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .RespValid(RespValid), .RespRData(RespRData), .RespErr(RespErr),
    .DMemAddr(DMemAddr), .DMemWrite(DMemWrite), .DMemWData(DMemWData),
    .DMemRData(DMemRData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (DMemWrite) mem[DMemAddr] <= DMemWData;
  assign DMemRData = mem[DMemAddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    logic [31:0] v;
    int base;
    base = int'(addr[7:0]) & 252;
    v = 0;
    for (int k = 0; k < 4; k++) v = v | (32'(ref_b[base + k]) << (8 * k));
    return v;
  endfunction

  // Issues one request, holds it until the response, and checks it against the byte model.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic hold, input string tag,
                        output logic [31:0] rd, output logic [31:0] wdat);
    int lat, nwr, size, exp_lat, base;
    logic er, bad;
    logic [31:0] exp_rd, wadr;
    bad  = wr ? (f3 > 3'd2) : !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    size = 1 << f3[1:0];
    if (!bad && ((int'(addr[1:0]) % size) != 0)) bad = 1'b1;
    base = int'(addr[7:0]);
    exp_rd = 0;
    if (!wr && !bad) begin
      for (int k = 0; k < size; k++) exp_rd = exp_rd | (32'(ref_b[(base + k) & 255]) << (8 * k));
      if (!f3[2] && size < 4 && exp_rd[8 * size - 1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8 * size));
    end
    exp_lat = bad ? 1 : (!wr ? 2 : (f3 == 3'd2 ? 2 : 3));

    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(ReqReady), 32'd1);
    ReqValid = 1'b1; ReqWrite = wr; ReqFunct3 = f3; ReqAddr = addr; ReqWData = wd;
    @(posedge clk);
    lat = 0; nwr = 0; rd = 32'hX; er = 1'bX; wdat = 32'h0; wadr = 32'h0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      check({tag, "_ready_busy"}, 32'(ReqReady), 32'd0);
      if (DMemWrite) begin
        nwr++; wdat = DMemWData; wadr = 32'(DMemAddr);
      end
      if (RespValid) begin
        rd = RespRData; er = RespErr; lat = cyc;
        if (!hold) ReqValid = 1'b0;
        break;
      end
    end
    if (lat == 0) ReqValid = 1'b0;

    if (wr && !bad) for (int k = 0; k < size; k++) ref_b[(base + k) & 255] = wd[8 * k +: 8];
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(er), 32'(bad));
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_wr_pulses"}, 32'(nwr), (wr && !bad) ? 32'd1 : 32'd0);
    if (wr && !bad) begin
      check({tag, "_wdata"}, wdat, ref_word(addr));
      check({tag, "_waddr"}, wadr, 32'(addr[7:2]));
    end
  endtask

  initial begin
    logic [31:0] rd, wd, a;
    logic [2:0]  f;
    logic        w;

    rst_n = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqFunct3 = 3'b0; ReqAddr = 0; ReqWData = 0;
    for (int i = 0; i < 256; i++) ref_b[i] = 8'h0;
    #12;
    check("rst_ready", 32'(ReqReady), 32'd1);
    check("rst_resp_valid", 32'(RespValid), 32'd0);
    check("rst_rdata", RespRData, 32'd0);
    check("rst_err", 32'(RespErr), 32'd0);
    check("rst_dmem_write", 32'(DMemWrite), 32'd0);
    check("rst_dmem_addr", 32'(DMemAddr), 32'd0);
    check("rst_dmem_wdata", DMemWData, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) do_req(1'b1, 3'b010, 32'(i * 4), 32'h0, 1'b0, "clear", rd, wd);

    // Word store then load, back-to-back with ReqValid held high.
    do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b1, "sw10", rd, wd);
    check("sw10_wdata_const", wd, 32'hDEAD_BEEF);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, "lw10", rd, wd);
    check("lw10_const", rd, 32'hDEAD_BEEF);
    do_req(1'b0, 3'b010, 32'h110, 32'h0, 1'b0, "lw_wrap", rd, wd);
    check("lw_wrap_const", rd, 32'hDEAD_BEEF);

    do_req(1'b1, 3'b010, 32'h04, 32'h1122_3344, 1'b0, "sw04", rd, wd);
    do_req(1'b1, 3'b000, 32'h06, 32'h0000_00AB, 1'b0, "sb06", rd, wd);
    check("sb06_merge_const", wd, 32'h11AB_3344);
    do_req(1'b1, 3'b001, 32'h06, 32'h0000_CAFE, 1'b0, "sh06", rd, wd);
    check("sh06_merge_const", wd, 32'hCAFE_3344);

    do_req(1'b1, 3'b010, 32'h08, 32'h80F0_7F01, 1'b0, "sw08", rd, wd);
    do_req(1'b0, 3'b000, 32'h09, 32'h0, 1'b0, "lb09", rd, wd);
    check("lb09_const", rd, 32'h0000_007F);
    do_req(1'b0, 3'b100, 32'h0A, 32'h0, 1'b0, "lbu0a", rd, wd);
    check("lbu0a_const", rd, 32'h0000_00F0);
    do_req(1'b0, 3'b001, 32'h0A, 32'h0, 1'b0, "lh0a", rd, wd);
    check("lh0a_const", rd, 32'hFFFF_80F0);
    do_req(1'b0, 3'b101, 32'h0A, 32'h0, 1'b0, "lhu0a", rd, wd);
    check("lhu0a_const", rd, 32'h0000_80F0);

    do_req(1'b0, 3'b010, 32'h13, 32'h0, 1'b0, "lw13_mis", rd, wd);
    do_req(1'b1, 3'b001, 32'h05, 32'hFFFF, 1'b0, "sh05_mis", rd, wd);
    do_req(1'b0, 3'b011, 32'h08, 32'h0, 1'b0, "ld011_ill", rd, wd);
    do_req(1'b1, 3'b100, 32'h08, 32'h1234, 1'b0, "st100_ill", rd, wd);
    check("err_mem_intact", mem[2], ref_word(32'h08));

    // Reset during the RD cycle of a byte store.
    @(negedge clk);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqFunct3 = 3'b000; ReqAddr = 32'h05; ReqWData = 32'h55;
    @(posedge clk);
    #2;
    ReqValid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ReqReady), 32'd1);
    check("mid_rst_resp_valid", 32'(RespValid), 32'd0);
    check("mid_rst_dmem_write", 32'(DMemWrite), 32'd0);
    check("mid_rst_dmem_addr", 32'(DMemAddr), 32'd0);
    check("mid_rst_dmem_wdata", DMemWData, 32'd0);
    check("mid_rst_rdata", RespRData, 32'd0);
    check("mid_rst_err", 32'(RespErr), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("in_rst_dmem_write", 32'(DMemWrite), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(ReqReady), 32'd1);
    check("post_rst_write", 32'(DMemWrite), 32'd0);
    check("post_rst_mem", mem[1], 32'hCAFE_3344);
    do_req(1'b0, 3'b010, 32'h04, 32'h0, 1'b0, "post_rst_lw", rd, wd);

    for (int n = 0; n < 60; n++) begin
      w = 1'($urandom_range(1));
      f = 3'($urandom_range(7));
      if (w && $urandom_range(3) != 0) f = 3'($urandom_range(2));
      a = $urandom;
      if ($urandom_range(1) == 1) a[1:0] = 2'b00;
      do_req(w, f, a, $urandom, (n != 59) && ($urandom_range(1) == 1), "rand", rd, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
